reg_alloc_ctrl: RTL and testbench

Hardware register allocator and arbiter for the expression-evaluation register file. It owns a free/busy bitmap of `NREGS` virtual registers and grants contiguous register ranges to two requesters: port 0 is the expression evaluator, port 1 is the call sequencer, which needs consecutive argument registers. It also accepts range frees and reports a live free count. It sits between the requesters and the register file, and is the sole authority on register ownership.

---
 rtl/reg_alloc_pkg.sv | 16 +
 rtl/reg_alloc_ctrl_rr_arb2.sv | 26 ++
 rtl/reg_alloc_ctrl.sv | 149 ++++++++++++++
 tb/tb_reg_alloc_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_alloc_pkg.sv
// Shared types and sizing helpers for the register allocator.
package reg_alloc_pkg;

  localparam int NREGS_DEF = 16;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reg_alloc_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; on a tie the port not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // prio=0 favours port 0, prio=1 favours port 1
  logic prio;

  // grant: a lone requester always wins, a tie goes to the favoured port
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !prio)) gnt = 2'b01;
    else if (req[1])                  gnt = 2'b10;
  end

  // after an accept, favour the port that just lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 prio <= 1'b0;
    else if (accept && |req)    prio <= gnt[0];
  end

endmodule

// File: rtl/reg_alloc_ctrl.sv
// Register allocator: busy bitmap, lowest-first contiguous range search,
// range frees with error flagging, and a registered free count.
module reg_alloc_ctrl
  import reg_alloc_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int IDX_W = idx_w(NREGS),
  parameter int CNT_W = cnt_w(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            alloc_valid,
  input  logic [1:0][CNT_W-1:0] alloc_count,
  output logic [1:0]            alloc_ready,
  output logic                  gnt_valid,
  output logic                  gnt_id,
  output logic [IDX_W-1:0]      gnt_base,
  output logic                  gnt_fail,
  input  logic                  free_valid,
  input  logic [IDX_W-1:0]      free_base,
  input  logic [CNT_W-1:0]      free_count,
  output logic [CNT_W-1:0]      free_regs,
  output logic                  busy,
  output logic                  err_free
);

  localparam logic [CNT_W-1:0] NREGS_C  = CNT_W'(NREGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);
  localparam int               FW       = CNT_W + 1;

  state_e             state, state_nxt;
  logic [NREGS-1:0]   busy_map, busy_nxt, alloc_mask, free_mask;
  logic [IDX_W-1:0]   scan_idx, idx_nxt, base_q, base_nxt;
  logic [CNT_W-1:0]   run_cnt, run_nxt, run_inc, req_cnt, cnt_nxt, base_w, pop;
  logic               req_id, id_nxt, fail_q, fail_nxt, free_err, accept;
  logic [1:0]         arb_gnt;
  logic [FW-1:0]      f_lo, f_hi;

  assign accept = (state == IDLE) && |alloc_valid;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (alloc_valid),
    .accept (accept),
    .gnt    (arb_gnt)
  );

  // FSM next state, request latch and the one-bit-per-cycle scan
  always_comb begin
    state_nxt   = state;
    idx_nxt     = scan_idx;
    run_nxt     = run_cnt;
    id_nxt      = req_id;
    cnt_nxt     = req_cnt;
    base_nxt    = base_q;
    fail_nxt    = fail_q;
    alloc_mask  = '0;
    alloc_ready = 2'b00;
    run_inc     = busy_map[scan_idx] ? '0 : run_cnt + CNT_W'(1);
    base_w      = CNT_W'(scan_idx) + CNT_W'(1) - req_cnt;
    unique case (state)
      IDLE: if (|alloc_valid) begin
        alloc_ready = arb_gnt;
        id_nxt      = arb_gnt[1];
        cnt_nxt     = alloc_count[arb_gnt[1]];
        base_nxt    = '0;
        idx_nxt     = '0;
        run_nxt     = '0;
        if (cnt_nxt == '0 || cnt_nxt > NREGS_C) begin
          fail_nxt  = 1'b1;
          state_nxt = RESP;
        end else begin
          fail_nxt  = 1'b0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        run_nxt = run_inc;
        if (run_inc == req_cnt) begin
          // range ends at the bit just examined; claim it this cycle
          base_nxt = base_w[IDX_W-1:0];
          for (int i = 0; i < NREGS; i++)
            alloc_mask[i] = (CNT_W'(i) >= base_w) && (CNT_W'(i) <= CNT_W'(scan_idx));
          state_nxt = RESP;
        end else if (scan_idx == LAST_IDX) begin
          fail_nxt  = 1'b1;
          state_nxt = RESP;
        end else begin
          idx_nxt = scan_idx + IDX_W'(1);
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // free range decode; any touched bit that is already free or out of range is an error
  always_comb begin
    f_lo      = FW'(free_base);
    f_hi      = f_lo + FW'(free_count);
    free_mask = '0;
    for (int i = 0; i < NREGS; i++)
      free_mask[i] = free_valid && (FW'(i) >= f_lo) && (FW'(i) < f_hi);
    free_err  = |(free_mask & ~busy_map) || (free_valid && f_hi > FW'(NREGS));
    // a free hitting a bit being claimed is already an error; the free wins
    busy_nxt  = (busy_map | alloc_mask) & ~free_mask;
  end

  // population count of the next bitmap feeds the registered free count
  always_comb begin
    pop = '0;
    for (int i = 0; i < NREGS; i++) pop = pop + CNT_W'(busy_nxt[i]);
  end

  // state, scan datapath, bitmap and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      scan_idx  <= '0;
      run_cnt   <= '0;
      req_id    <= 1'b0;
      req_cnt   <= '0;
      base_q    <= '0;
      fail_q    <= 1'b0;
      busy_map  <= '0;
      free_regs <= NREGS_C;
      err_free  <= 1'b0;
    end else begin
      state     <= state_nxt;
      scan_idx  <= idx_nxt;
      run_cnt   <= run_nxt;
      req_id    <= id_nxt;
      req_cnt   <= cnt_nxt;
      base_q    <= base_nxt;
      fail_q    <= fail_nxt;
      busy_map  <= busy_nxt;
      free_regs <= NREGS_C - pop;
      if (free_err) err_free <= 1'b1;
    end
  end

  assign gnt_valid = (state == RESP);
  assign gnt_id    = gnt_valid & req_id;
  assign gnt_fail  = gnt_valid & fail_q;
  assign gnt_base  = (gnt_valid && !fail_q) ? base_q : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_reg_alloc_ctrl.sv
// Bench for reg_alloc_ctrl: abstract bitmap model checked every cycle plus
// directed scenarios with hand-computed grant bases and latencies.
module tb_reg_alloc_ctrl;

  localparam int NREGS = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [1:0]            alloc_valid = '0;
  logic [1:0][CNT_W-1:0] alloc_count = '0;
  logic [1:0]            alloc_ready;
  logic                  gnt_valid, gnt_id, gnt_fail, busy, err_free;
  logic [IDX_W-1:0]      gnt_base;
  logic                  free_valid = 1'b0;
  logic [IDX_W-1:0]      free_base = '0;
  logic [CNT_W-1:0]      free_count = '0;
  logic [CNT_W-1:0]      free_regs;

  always #5 clk = ~clk;

  reg_alloc_ctrl #(.NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_count(alloc_count), .alloc_ready(alloc_ready),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_base(gnt_base), .gnt_fail(gnt_fail),
    .free_valid(free_valid), .free_base(free_base), .free_count(free_count),
    .free_regs(free_regs), .busy(busy), .err_free(err_free)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               cyc = 0;
  logic [NREGS-1:0] m_busy = '0;
  logic             m_err = 1'b0, m_prio = 1'b0, m_pend = 1'b0, m_id = 1'b0, m_fail = 1'b0;
  int               m_base = 0, m_cnt = 0, m_resp = -1, m_commit = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin : model
    logic [NREGS-1:0] fmask, amask, nb;
    logic err, ok, found;
    int w, c, b, k;
    if (!rst_n) begin
      m_busy <= '0; m_err <= 1'b0; m_prio <= 1'b0; m_pend <= 1'b0;
      m_resp <= -1; m_commit <= -1;
    end else begin
      fmask = '0; amask = '0; err = m_err;
      if (free_valid)
        for (int i = 0; i < int'(free_count); i++) begin
          k = int'(free_base) + i;
          if (k >= NREGS) err = 1'b1;
          else begin
            if (!m_busy[k]) err = 1'b1;
            fmask[k] = 1'b1;
          end
        end
      if (m_pend && cyc == m_commit)
        for (int i = 0; i < m_cnt; i++) amask[m_base + i] = 1'b1;
      nb = (m_busy | amask) & ~fmask;
      m_busy <= nb;
      m_err  <= err;
      if (m_pend && cyc == m_resp) m_pend <= 1'b0;
      else if (!m_pend && alloc_valid != 2'b00) begin
        w = (alloc_valid == 2'b11) ? int'(m_prio) : (alloc_valid[1] ? 1 : 0);
        c = int'(alloc_count[w]);
        m_prio <= (w == 0);
        m_id   <= (w == 1);
        m_cnt  <= c;
        m_pend <= 1'b1;
        found = 1'b0; b = 0;
        if (c >= 1 && c <= NREGS)
          for (int s = 0; s <= NREGS - c; s++)
            if (!found) begin
              ok = 1'b1;
              for (int j = 0; j < c; j++) if (nb[s + j]) ok = 1'b0;
              if (ok) begin found = 1'b1; b = s; end
            end
        if (c < 1 || c > NREGS) begin
          m_fail <= 1'b1; m_base <= 0; m_commit <= -1; m_resp <= cyc + 1;
        end else if (found) begin
          m_fail <= 1'b0; m_base <= b; m_commit <= cyc + b + c; m_resp <= cyc + b + c + 1;
        end else begin
          m_fail <= 1'b1; m_base <= 0; m_commit <= -1; m_resp <= cyc + 1 + NREGS;
        end
      end
    end
  end

  // every-cycle comparison of the DUT against the model
  always @(negedge clk) begin : compare
    logic [1:0] er;
    logic ev;
    int w;
    if (rst_n) begin
      er = 2'b00;
      if (!m_pend && alloc_valid != 2'b00) begin
        w = (alloc_valid == 2'b11) ? int'(m_prio) : (alloc_valid[1] ? 1 : 0);
        er[w] = 1'b1;
      end
      ev = m_pend && (cyc == m_resp);
      chk("alloc_ready", int'(alloc_ready), int'(er));
      chk("gnt_valid", int'(gnt_valid), int'(ev));
      chk("busy", int'(busy), int'(m_pend));
      chk("free_regs", int'(free_regs), NREGS - $countones(m_busy));
      chk("err_free", int'(err_free), int'(m_err));
      if (ev) begin
        chk("gnt_id", int'(gnt_id), int'(m_id));
        chk("gnt_fail", int'(gnt_fail), int'(m_fail));
        chk("gnt_base", int'(gnt_base), m_fail ? 0 : m_base);
      end
    end
  end

  // ---------------- response monitor ----------------
  typedef struct { int id; int base; int fail; int lat; } resp_t;
  resp_t q[$];
  int    acc_cyc[2];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) if (alloc_ready[p]) acc_cyc[p] <= cyc;
      if (gnt_valid)
        q.push_back('{int'(gnt_id), int'(gnt_base), int'(gnt_fail), cyc - acc_cyc[int'(gnt_id)]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int p, input int c);
    int t = 0;
    logic got = 1'b0;
    alloc_valid[p] = 1'b1;
    alloc_count[p] = CNT_W'(c);
    while (!got && t < 60) begin
      @(negedge clk);
      got = alloc_ready[p];
      tick();
      t++;
    end
    alloc_valid[p] = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: port %0d never got alloc_ready", p);
    end
  endtask

  task automatic send2(input int c0, input int c1);
    int t = 0;
    logic [1:0] done = 2'b00, r;
    alloc_valid = 2'b11;
    alloc_count[0] = CNT_W'(c0);
    alloc_count[1] = CNT_W'(c1);
    while (done != 2'b11 && t < 60) begin
      @(negedge clk);
      r = alloc_ready;
      tick();
      done = done | r;
      alloc_valid = alloc_valid & ~r;
      t++;
    end
    alloc_valid = 2'b00;
    if (done != 2'b11) begin
      n_cmp++; n_fail++;
      $display("FAIL accept2_timeout: accepted mask %0d, required 3", done);
    end
  endtask

  task automatic get_resp(input string nm, input int id, input int base, input int fail, input int lat);
    int t = 0;
    resp_t r;
    while (q.size() == 0 && t < 40) begin tick(); t++; end
    if (q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: no gnt_valid seen, one required", nm);
    end else begin
      r = q.pop_front();
      chk({nm, "_id"}, r.id, id);
      chk({nm, "_base"}, r.base, base);
      chk({nm, "_fail"}, r.fail, fail);
      chk({nm, "_lat"}, r.lat, lat);
    end
  endtask

  task automatic free_op(input int b, input int c);
    free_valid = 1'b1;
    free_base  = IDX_W'(b);
    free_count = CNT_W'(c);
    tick();
    free_valid = 1'b0;
    free_count = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    tick(); tick();
    chk("rst_alloc_ready", int'(alloc_ready), 0);
    chk("rst_gnt_valid", int'(gnt_valid), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    chk("rst_gnt_base", int'(gnt_base), 0);
    chk("rst_gnt_fail", int'(gnt_fail), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err_free", int'(err_free), 0);
    chk("rst_free_regs", int'(free_regs), 16);
    rst_n = 1'b1;
    tick();

    // reset allocation and search past a short hole
    send(0, 3);  get_resp("first", 0, 0, 0, 4);
    chk("free_after_first", int'(free_regs), 13);
    send(0, 3);  get_resp("second", 0, 3, 0, 7);
    free_op(3, 2);
    chk("free_hold_0_2_5", int'(free_regs), 12);
    free_op(1, 1);
    chk("free_after_hole", int'(free_regs), 13);
    send(1, 3);  get_resp("hole", 1, 6, 0, 10);
    chk("free_after_hole_alloc", int'(free_regs), 10);

    // simultaneous requests and round-robin fairness
    do_reset();
    send2(1, 1);
    get_resp("rr0", 0, 0, 0, 2);
    get_resp("rr1", 1, 1, 0, 3);
    send2(1, 1);
    get_resp("rr2", 0, 2, 0, 4);
    get_resp("rr3", 1, 3, 0, 5);

    // fail paths
    do_reset();
    send(0, 0);   get_resp("cnt0", 0, 0, 1, 1);
    send(1, 17);  get_resp("cnt17", 1, 0, 1, 1);
    send(0, 16);  get_resp("all16", 0, 0, 0, 17);
    chk("free_full", int'(free_regs), 0);
    send(1, 1);   get_resp("full_fail", 1, 0, 1, 17);
    chk("free_full_kept", int'(free_regs), 0);

    // free landing on the same cycle as an alloc commit
    do_reset();
    send(0, 8);  get_resp("blk8", 0, 0, 0, 9);
    send(1, 2);
    repeat (9) tick();
    free_op(0, 2);
    get_resp("commit_free", 1, 8, 0, 11);
    chk("free_commit_free", int'(free_regs), 8);
    chk("err_after_clean", int'(err_free), 0);
    free_op(5, 0);
    chk("err_zero_count", int'(err_free), 0);
    free_op(0, 1);
    chk("err_double_free", int'(err_free), 1);
    chk("free_double_free", int'(free_regs), 8);
    repeat (3) tick();
    chk("err_sticky", int'(err_free), 1);

    // reset during a scan
    do_reset();
    send(0, 5);  get_resp("pre_abort", 0, 0, 0, 6);
    send(1, 4);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_free_regs", int'(free_regs), 16);
    chk("abort_busy", int'(busy), 0);
    chk("abort_gnt_valid", int'(gnt_valid), 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("abort_no_gnt", q.size(), 0);
    chk("abort_free_after", int'(free_regs), 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
